adder_disp_core: RTL and testbench

Parametrised successor to the switch-driven adder/display top. It is a registered signed add/subtract/accumulate unit with a go/busy/done handshake. It drives a time-multiplexed DIGITS-wide seven-segment display of the result in hex. It sits between board I/O (switches and debounced button) and the seven-segment pins.

---
 rtl/adder_disp_pkg.sv | 29 ++
 rtl/adder_disp_core_seg_scan.sv | 63 ++++++
 rtl/adder_disp_core.sv | 84 ++++++++
 tb/tb_adder_disp_core.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/adder_disp_pkg.sv
// adder_disp_pkg: shared types, constants and arithmetic helper for adder_disp_core
// Contents:
//   state_t   - operation FSM states (IDLE, CALC, DONE)
//   MAXW      - internal sum width, wide enough for the largest WIDTH (12) plus guard bits
//   HEX_SEG   - hex digit to active-low seven-segment pattern (bit0=a .. bit6=g)
//   SEG_BLANK - all segments off
//   add_sub   - signed add/subtract with overflow taken at a run-time result width
package adder_disp_pkg;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    localparam int MAXW = 14;
    localparam logic [6:0] SEG_BLANK = 7'h7f;
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0e, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };
    typedef struct packed {
        logic [MAXW-1:0] s;
        logic            ov;
    } sum_t;
    // Operands arrive sign-extended to MAXW, so bits rw and rw-1 of the wide
    // sum match the top two bits of an (rw+1)-bit sum.
    function automatic sum_t add_sub(input logic [MAXW-1:0] x, input logic [MAXW-1:0] y,
                                     input logic sub, input logic [3:0] rw);
        sum_t r;
        r.s  = sub ? x - y : x + y;
        r.ov = r.s[rw] ^ r.s[rw - 4'd1];
        return r;
    endfunction
endpackage

// File: rtl/adder_disp_core_seg_scan.sv
// seg_scan: time-multiplexed hex seven-segment driver
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   value     - 4*DIGITS-bit value, nibble k shown on digit k (digit 0 rightmost)
//   ov        - lights dp on digit 0 when set
//   seg       - active-low cathodes, seg[0]=a .. seg[6]=g
//   an        - active-low one-hot anodes
//   dp        - active-low decimal point
// Macro OVF_BLINK_EN: blank all anodes for BLINK_DIV clocks out of every 2*BLINK_DIV while ov=1.
module seg_scan
    import adder_disp_pkg::*;
#(
    parameter int DIGITS    = 2,
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  ov,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  dp
);
    localparam int CW = $clog2(SCAN_DIV + 1);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    logic [CW-1:0]     cnt;
    logic [IW-1:0]     idx;
    logic [3:0]        nib;
    logic [DIGITS-1:0] an_scan;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CW'(SCAN_DIV - 1)) begin
            cnt <= '0;
            idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
    // seg and an are both decoded from idx, so they switch on the same edge
    assign nib     = 4'(value >> {idx, 2'b00});
    assign seg     = HEX_SEG[nib];
    assign an_scan = ~(DIGITS'(1) << idx);
    assign dp      = ~(ov && idx == '0);
`ifdef OVF_BLINK_EN
    localparam int BW = $clog2(2 * BLINK_DIV);
    logic [BW-1:0] bcnt;
    // held at 0 while ov is low, so every rise of ov starts a blank phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bcnt <= '0;
        else if (!ov || bcnt == BW'(2 * BLINK_DIV - 1))
            bcnt <= '0;
        else
            bcnt <= bcnt + 1'b1;
    end
    assign an = (ov && bcnt < BW'(BLINK_DIV)) ? '1 : an_scan;
`else
    assign an = an_scan;
`endif
endmodule

// File: rtl/adder_disp_core.sv
// adder_disp_core: registered signed add/sub/accumulate unit with go/busy/done and hex display
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   a, b         - WIDTH-bit two's complement operands
//   sub, acc     - subtract select, accumulate select (R op B instead of A op B)
//   go           - start request, accepted only in IDLE
//   busy, done   - operation in progress, one-cycle completion pulse
//   result, ov   - WIDTH+1-bit result register, signed overflow of last operation
//   seg, an, dp  - active-low seven-segment cathodes, anodes, decimal point
// Macro OVF_BLINK_EN: blink the display while ov=1 (see seg_scan).
module adder_disp_core
    import adder_disp_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int DIGITS    = 2,
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              sub,
    input  logic              acc,
    input  logic              go,
    output logic              busy,
    output logic              done,
    output logic [WIDTH:0]    result,
    output logic              ov,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an,
    output logic              dp
);
    localparam int RW = WIDTH + 1;
    state_t           state, state_n;
    logic [WIDTH-1:0] a_q, b_q;
    logic             sub_q, acc_q;
    logic [MAXW-1:0]  x, y;
    sum_t             s;
    assign x = acc_q ? {{(MAXW-RW){result[RW-1]}}, result} : {{(MAXW-WIDTH){a_q[WIDTH-1]}}, a_q};
    assign y = {{(MAXW-WIDTH){b_q[WIDTH-1]}}, b_q};
    assign s = add_sub(x, y, sub_q, 4'(RW));
    always_comb begin
        state_n = (state == IDLE) ? (go ? CALC : IDLE) : (state == CALC) ? DONE : IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            sub_q  <= 1'b0;
            acc_q  <= 1'b0;
            result <= '0;
            ov     <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && go) begin
                a_q   <= a;
                b_q   <= b;
                sub_q <= sub;
                acc_q <= acc;
            end
            if (state == CALC) begin
                result <= s.s[RW-1:0];
                ov     <= s.ov;
            end
        end
    end
    assign busy = state != IDLE;
    assign done = state == DONE;
    seg_scan #(
        .DIGITS    (DIGITS),
        .SCAN_DIV  (SCAN_DIV),
        .BLINK_DIV (BLINK_DIV)
    ) u_scan (
        .clk   (clk),
        .rst   (rst),
        .value ((4*DIGITS)'(result)),
        .ov    (ov),
        .seg   (seg),
        .an    (an),
        .dp    (dp)
    );
endmodule

// File: tb/tb_adder_disp_core.sv
// tb_adder_disp_core: directed and randomized checks of adder_disp_core (WIDTH=4, DIGITS=2, SCAN_DIV=4)
module tb_adder_disp_core;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] a = '0, b = '0;
    logic       sub = 1'b0, acc = 1'b0, go = 1'b0;
    logic       busy, done, ov, dp;
    logic [4:0] result;
    logic [6:0] seg;
    logic [1:0] an;
    int n_asrt = 0, n_fail = 0;
    int m_r = 0;
    int m_ov = 0;
    int cyc = 0;
    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0e};

    adder_disp_core #(.WIDTH(4), .DIGITS(2), .SCAN_DIV(4), .BLINK_DIV(8)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .sub(sub), .acc(acc), .go(go),
        .busy(busy), .done(done), .result(result), .ov(ov),
        .seg(seg), .an(an), .dp(dp)
    );

    always #5 clk = ~clk;

    // posedges since reset release; the scan position is floor(cyc/4) mod 2
    always @(posedge clk or posedge rst) cyc <= rst ? 0 : cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic disp_check(input int n);
        for (int i = 0; i < n; i++) begin
            int k;
            @(negedge clk);
            k = (cyc / 4) % 2;
            check("an", 32'(an), k ? 32'h1 : 32'h2);
            check("seg", 32'(seg), 32'(hex_tab[(m_r >> (4 * k)) & 15]));
            check("dp", 32'(dp), (k == 0 && m_ov == 1) ? 32'h0 : 32'h1);
        end
    endtask

    // called at a negedge with the DUT idle
    task automatic do_op(input logic [3:0] ta, input logic [3:0] tb_, input logic ts, input logic tac);
        int x, y, s;
        x = tac ? ((m_r >= 16) ? m_r - 32 : m_r) : int'($signed(ta));
        y = int'($signed(tb_));
        s = ts ? x - y : x + y;
        a = ta; b = tb_; sub = ts; acc = tac; go = 1'b1;
        @(posedge clk);
        #1;
        go = 1'b0;
        a = 4'($urandom); b = 4'($urandom); sub = 1'($urandom); acc = 1'($urandom);
        @(negedge clk);
        check("busy_calc", 32'(busy), 1);
        check("done_calc", 32'(done), 0);
        m_r = s & 31;
        m_ov = (s > 15 || s < -16) ? 1 : 0;
        @(negedge clk);
        check("busy_done", 32'(busy), 1);
        check("done_pulse", 32'(done), 1);
        check("result", 32'(result), 32'(m_r));
        check("ov", 32'(ov), 32'(m_ov));
        @(negedge clk);
        check("busy_idle", 32'(busy), 0);
        check("done_idle", 32'(done), 0);
    endtask

    task automatic reset_dut;
        @(negedge clk);
        rst = 1'b1;
        m_r = 0;
        m_ov = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int dones;
        #2;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_result", 32'(result), 0);
        check("rst_ov", 32'(ov), 0);
        check("rst_an", 32'(an), 32'h2);
        check("rst_seg", 32'(seg), 32'h40);
        check("rst_dp", 32'(dp), 1);
        @(negedge clk);
        rst = 1'b0;

        do_op(4'd3, 4'd2, 1'b0, 1'b0);
        check("t1_r", 32'(result), 32'h05);
        disp_check(8);

        do_op(4'h8, 4'd1, 1'b1, 1'b0);
        check("t2_r", 32'(result), 32'h17);
        check("t2_ov", 32'(ov), 0);
        disp_check(8);

        reset_dut();
        do_op(4'h0, 4'd7, 1'b0, 1'b1);
        check("t3_r1", 32'(result), 32'h07);
        do_op(4'h0, 4'd7, 1'b0, 1'b1);
        check("t3_r2", 32'(result), 32'h0e);
        do_op(4'h0, 4'd7, 1'b0, 1'b1);
        check("t3_r3", 32'(result), 32'h15);
        check("t3_ov", 32'(ov), 1);
        disp_check(8);

        // go held high: one operation every 3 cycles
        a = 4'd1; b = 4'd1; sub = 1'b0; acc = 1'b0; go = 1'b1;
        dones = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            dones += int'(done);
        end
        go = 1'b0;
        check("held_dones", 32'(dones), 3);
        check("held_busy", 32'(busy), 0);
        m_r = 2; m_ov = 0;
        check("held_r", 32'(result), 32'h02);

        // go pulse during CALC is ignored
        a = 4'd5; b = 4'd6; sub = 1'b1; acc = 1'b0; go = 1'b1;
        @(posedge clk);
        #1;
        a = 4'd7; b = 4'd7; sub = 1'b0;
        dones = 0;
        @(posedge clk);
        #1;
        go = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            dones += int'(done);
        end
        check("calc_go_dones", 32'(dones), 1);
        m_r = 31; m_ov = 0;
        check("calc_go_r", 32'(result), 32'h1f);
        disp_check(4);

        // reset during CALC
        a = 4'd2; b = 4'd3; sub = 1'b0; acc = 1'b0; go = 1'b1;
        @(posedge clk);
        #1;
        go = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        m_r = 0; m_ov = 0;
        check("mid_busy", 32'(busy), 0);
        check("mid_done", 32'(done), 0);
        check("mid_result", 32'(result), 0);
        check("mid_an", 32'(an), 32'h2);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            dones += int'(done);
        end
        check("mid_nodone", 32'(dones), 0);
        check("mid_result2", 32'(result), 0);

        for (int i = 0; i < 24; i++) begin
            do_op(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
            disp_check(3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $fatal(1, "FAIL timeout: observed no end of test, expected finish");
    end
endmodule
